// File: rtl/pe_wavefront_scheduler_if.sv
// Interface bundling the scheduler's job, PE-array and status signals.
// The scheduler connects through the slave modport; the front-end / PE
// array side (or a testbench) uses the master modport.
`timescale 1ns/1ps

interface pe_wavefront_scheduler_if #(
    parameter int NUM_PE = 8,
    parameter int LEN_W  = 8,
    parameter int TAG_W  = 8
) ();
    logic              start;
    logic [LEN_W-1:0]  read_len;
    logic [LEN_W-1:0]  hap_len;
    logic              global_stall;
    logic [NUM_PE-1:0] pe_done;
    logic [NUM_PE-1:0] pe_stall;
    logic [NUM_PE-1:0] pe_enable;
    logic              pe_advance;
    logic              set_tb_special;
    logic [TAG_W-1:0]  tag_out;
    logic [LEN_W:0]    diag;
    logic              busy;
    logic              job_done;
    logic              len_err;
    logic              timeout_err;

    modport slave (
        input  start, read_len, hap_len, global_stall, pe_done, pe_stall,
        output pe_enable, pe_advance, set_tb_special, tag_out, diag,
               busy, job_done, len_err, timeout_err
    );

    modport master (
        output start, read_len, hap_len, global_stall, pe_done, pe_stall,
        input  pe_enable, pe_advance, set_tb_special, tag_out, diag,
               busy, job_done, len_err, timeout_err
    );
endinterface

// File: rtl/pe_wavefront_scheduler.sv
// Wavefront scheduler for a linear array of NUM_PE Pair-HMM processing
// elements. Read row i runs on PE i while the haplotype streams through as
// columns; the scheduler walks anti-diagonals 0 .. read_len+hap_len-2,
// enabling the PEs that own a cell on the current diagonal, waiting for them
// to finish, then issuing one broadcast advance per diagonal.
// Optional feature: define SCHED_TIMEOUT_EN to add a per-diagonal watchdog
// (parameter TIMEOUT_CYC); without it timeout_err is tied low.
`timescale 1ns/1ps

module pe_wavefront_scheduler #(
    parameter int NUM_PE = 8,
    parameter int LEN_W  = 8,
    parameter int TAG_W  = 8
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    pe_wavefront_scheduler_if.slave sif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ADV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [LEN_W:0] DIAG_TWO = (LEN_W+1)'(2);

    state_t            state_q, state_d;
    logic [LEN_W:0]    diag_q, diag_d;
    logic [LEN_W-1:0]  rlen_q, rlen_d;
    logic [LEN_W-1:0]  hlen_q, hlen_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [NUM_PE-1:0] en_q, en_d;
    logic              len_err_q, len_err_d;

    logic              len_ok;
    logic              stall_any;
    logic              all_done;
    logic              can_adv;
    logic              last_diag;
    logic [LEN_W:0]    last_idx;
    logic [LEN_W:0]    diag_inc;
    logic              wd_expired;

    // PE i owns cell (row i, column d-i); it is active when that cell exists.
    function automatic logic [NUM_PE-1:0] enable_mask(input logic [LEN_W:0]   d,
                                                      input logic [LEN_W-1:0] r,
                                                      input logic [LEN_W-1:0] h);
        logic [NUM_PE-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if ((i < int'(r)) && (i <= int'(d)) && ((int'(d) - i) < int'(h))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign len_ok    = (sif.read_len != '0) && (sif.hap_len != '0) &&
                       (int'(sif.read_len) <= NUM_PE);
    assign stall_any = sif.global_stall | (|sif.pe_stall);
    // Idle PEs are masked out so only enabled PEs can hold the diagonal.
    assign all_done  = &(sif.pe_done | ~en_q);
    assign can_adv   = all_done && !stall_any;
    assign last_idx  = {1'b0, rlen_q} + {1'b0, hlen_q} - DIAG_TWO;
    assign last_diag = (diag_q == last_idx);
    assign diag_inc  = diag_q + 1'b1;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_err_q, to_err_d;

    assign wd_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog next state: counts every WAIT cycle (stalls included), zero elsewhere.
    always_comb begin
        cnt_d    = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
        to_err_d = (state_q == S_WAIT) && (state_d == S_IDLE);
    end

    // Watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign sif.timeout_err = to_err_q;
`else
    assign wd_expired      = 1'b0;
    assign sif.timeout_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; advancing takes priority over a watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (sif.start && len_ok) state_d = S_WAIT;
            S_WAIT: begin
                if (can_adv) begin
                    state_d = S_ADV;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_ADV:  state_d = last_diag ? S_FIN : S_WAIT;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Job registers next state: lengths, tag, diagonal, enables, length error.
    always_comb begin
        rlen_d    = rlen_q;
        hlen_d    = hlen_q;
        tag_d     = tag_q;
        diag_d    = diag_q;
        en_d      = en_q;
        len_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    if (len_ok) begin
                        rlen_d = sif.read_len;
                        hlen_d = sif.hap_len;
                        tag_d  = tag_q + 1'b1;
                        diag_d = '0;
                        en_d   = enable_mask('0, sif.read_len, sif.hap_len);
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (state_d == S_IDLE) en_d = '0;
            end
            S_ADV: begin
                if (last_diag) begin
                    en_d = '0;
                end else begin
                    diag_d = diag_inc;
                    en_d   = enable_mask(diag_inc, rlen_q, hlen_q);
                end
            end
            default: en_d = '0;
        endcase
    end

    // Job registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rlen_q    <= '0;
            hlen_q    <= '0;
            tag_q     <= '0;
            diag_q    <= '0;
            en_q      <= '0;
            len_err_q <= 1'b0;
        end else begin
            rlen_q    <= rlen_d;
            hlen_q    <= hlen_d;
            tag_q     <= tag_d;
            diag_q    <= diag_d;
            en_q      <= en_d;
            len_err_q <= len_err_d;
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        sif.pe_advance     = (state_q == S_ADV);
        sif.job_done       = (state_q == S_FIN);
        sif.busy           = (state_q != S_IDLE);
        sif.set_tb_special = (state_q == S_WAIT) && (diag_q == '0);
    end

    assign sif.pe_enable = en_q;
    assign sif.tag_out   = tag_q;
    assign sif.diag      = diag_q;
    assign sif.len_err   = len_err_q;

endmodule

// File: tb/tb_pe_wavefront_scheduler.sv
// Self-checking bench for pe_wavefront_scheduler with NUM_PE=4.
`timescale 1ns/1ps

module tb_pe_wavefront_scheduler;
    localparam int NUM_PE = 4;
    localparam int LEN_W  = 8;
    localparam int TAG_W  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pe_wavefront_scheduler_if #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .TAG_W(TAG_W)) sif ();

`ifdef SCHED_TIMEOUT_EN
    pe_wavefront_scheduler #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .TAG_W(TAG_W), .TIMEOUT_CYC(16))
        dut (.clock(clock), .reset(reset), .sif(sif));
`else
    pe_wavefront_scheduler #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .TAG_W(TAG_W))
        dut (.clock(clock), .reset(reset), .sif(sif));
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [TAG_W-1:0] exp_tag = '0;

    typedef struct {
        int       r;
        int       h;
        bit       err;
        logic [3:0] mask0;
        int       ndiag;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cells of the strip on anti-diagonal d: (row, col) with row+col == d.
    function automatic logic [3:0] ref_mask(input int d, input int r, input int h);
        logic [3:0] m;
        m = 4'b0;
        for (int row = 0; row < r; row++)
            for (int col = 0; col < h; col++)
                if (row + col == d) m[row] = 1'b1;
        return m;
    endfunction

    task automatic drive_idle();
        sif.start        = 1'b0;
        sif.global_stall = 1'b0;
        sif.pe_stall     = '0;
        sif.pe_done      = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the next negedge.
    task automatic do_start(input int r, input int h);
        sif.start        = 1'b1;
        sif.read_len     = LEN_W'(r);
        sif.hap_len      = LEN_W'(h);
        sif.global_stall = 1'b0;
        sif.pe_stall     = '0;
        sif.pe_done      = '0;
        @(negedge clock);
        sif.start = 1'b0;
    endtask

    // Runs a legal job from the first WAIT cycle to the IDLE cycle after FIN.
    task automatic run_body(input int r, input int h, input int stall_pct,
                            input bit noisy, output int n_adv);
        int d, age, dly, last, phase, nxt;
        bit gs;
        logic [3:0] m, ps, dn;
        d = 0; age = 0; dly = int'($urandom_range(0, 2)); last = r + h - 2;
        n_adv = 0; phase = 0;
        for (int cyc = 0; cyc < 600 && phase != 4; cyc++) begin
            m = ref_mask(d, r, h);
            check("tag_out", 32'(sif.tag_out), 32'(exp_tag));
            check("len_err_busy", 32'(sif.len_err), 32'd0);
            check("timeout_err", 32'(sif.timeout_err), 32'd0);
            case (phase)
                0: begin
                    check("wait_adv", 32'(sif.pe_advance), 32'd0);
                    check("wait_done", 32'(sif.job_done), 32'd0);
                    check("wait_busy", 32'(sif.busy), 32'd1);
                    check("wait_en", 32'(sif.pe_enable), 32'(m));
                    check("wait_diag", 32'(sif.diag), 32'(d));
                    check("tb_special", 32'(sif.set_tb_special), 32'(d == 0));
                end
                1: begin
                    check("adv_pulse", 32'(sif.pe_advance), 32'd1);
                    check("adv_en", 32'(sif.pe_enable), 32'(m));
                    check("adv_diag", 32'(sif.diag), 32'(d));
                    check("adv_tbs", 32'(sif.set_tb_special), 32'd0);
                    n_adv++;
                end
                2: begin
                    check("fin_done", 32'(sif.job_done), 32'd1);
                    check("fin_en", 32'(sif.pe_enable), 32'd0);
                    check("fin_adv", 32'(sif.pe_advance), 32'd0);
                end
                default: begin
                    check("idle_busy", 32'(sif.busy), 32'd0);
                    check("idle_done", 32'(sif.job_done), 32'd0);
                    check("idle_en", 32'(sif.pe_enable), 32'd0);
                end
            endcase
            gs = ($urandom_range(0, 99) < stall_pct);
            ps = ($urandom_range(0, 99) < stall_pct / 2) ? 4'($urandom_range(1, 15)) : 4'b0;
            dn = 4'($urandom);
            nxt = phase + 1;
            case (phase)
                0: begin
                    dn = (age >= dly) ? m : 4'b0;
                    if (noisy) dn = dn | (4'($urandom) & ~m);
                    nxt = (age >= dly && !gs && ps == 4'b0) ? 1 : 0;
                    age++;
                end
                1: begin
                    if (d == last) begin
                        nxt = 2;
                    end else begin
                        d++; age = 0; dly = int'($urandom_range(0, 2)); nxt = 0;
                    end
                end
                default: nxt = phase + 1;
            endcase
            if (phase <= 2 && $urandom_range(0, 3) == 0) begin
                sif.start    = 1'b1;
                sif.read_len = LEN_W'($urandom_range(0, 6));
                sif.hap_len  = LEN_W'($urandom_range(0, 9));
            end else begin
                sif.start = 1'b0;
            end
            sif.global_stall = gs;
            sif.pe_stall     = ps;
            sif.pe_done      = dn;
            phase = nxt;
            if (phase != 4) @(negedge clock);
        end
        if (phase != 4) check("job_cycle_bound", 32'(phase), 32'd4);
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq[6];
        int nadv, r, h;
        tbl[0] = '{4, 3, 1'b0, 4'b0001, 6};
        tbl[1] = '{1, 1, 1'b0, 4'b0001, 1};
        tbl[2] = '{0, 3, 1'b1, 4'b0000, 0};
        tbl[3] = '{5, 2, 1'b1, 4'b0000, 0};
        tbl[4] = '{3, 0, 1'b1, 4'b0000, 0};
        tbl[5] = '{2, 5, 1'b0, 4'b0001, 6};
        tbl[6] = '{4, 1, 1'b0, 4'b0001, 4};
        seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};

        drive_idle();
        sif.read_len = '0;
        sif.hap_len  = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_en", 32'(sif.pe_enable), 32'd0);
        check("rst_adv", 32'(sif.pe_advance), 32'd0);
        check("rst_tbs", 32'(sif.set_tb_special), 32'd0);
        check("rst_tag", 32'(sif.tag_out), 32'd0);
        check("rst_diag", 32'(sif.diag), 32'd0);
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.job_done), 32'd0);
        check("rst_len_err", 32'(sif.len_err), 32'd0);
        check("rst_timeout", 32'(sif.timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table of directed jobs, legal and illegal.
        for (int k = 0; k < 7; k++) begin
            do_start(tbl[k].r, tbl[k].h);
            if (tbl[k].err) begin
                check("len_err_pulse", 32'(sif.len_err), 32'd1);
                check("len_err_busy", 32'(sif.busy), 32'd0);
                check("len_err_tag", 32'(sif.tag_out), 32'(exp_tag));
                @(negedge clock);
                check("len_err_clear", 32'(sif.len_err), 32'd0);
                check("len_err_idle", 32'(sif.busy), 32'd0);
            end else begin
                exp_tag++;
                check("tbl_mask0", 32'(sif.pe_enable), 32'(tbl[k].mask0));
                check("tbl_no_len_err", 32'(sif.len_err), 32'd0);
                run_body(tbl[k].r, tbl[k].h, 0, 1'b0, nadv);
                check("tbl_ndiag", 32'(nadv), 32'(tbl[k].ndiag));
            end
        end

        // 4x3 job with a 5-cycle global stall on diagonal 2.
        do_start(4, 3);
        exp_tag++;
        for (int k = 0; k < 6; k++) begin
            check("seq_diag", 32'(sif.diag), 32'(k));
            check("seq_en", 32'(sif.pe_enable), 32'(seq[k]));
            sif.pe_done = sif.pe_enable;
            if (k == 2) begin
                sif.global_stall = 1'b1;
                repeat (5) begin
                    @(negedge clock);
                    check("stall_no_adv", 32'(sif.pe_advance), 32'd0);
                    check("stall_diag", 32'(sif.diag), 32'd2);
                end
                sif.global_stall = 1'b0;
            end
            @(negedge clock);
            check("seq_adv", 32'(sif.pe_advance), 32'd1);
            sif.pe_done = '0;
            @(negedge clock);
        end
        check("seq_done", 32'(sif.job_done), 32'd1);
        check("seq_tag", 32'(sif.tag_out), 32'(exp_tag));
        check("seq_fin_en", 32'(sif.pe_enable), 32'd0);
        @(negedge clock);
        check("seq_idle", 32'(sif.busy), 32'd0);
        check("seq_done_once", 32'(sif.job_done), 32'd0);

        // Reset while waiting on diagonal 3, then a clean job.
        do_start(4, 3);
        exp_tag++;
        for (int k = 0; k < 3; k++) begin
            sif.pe_done = sif.pe_enable;
            @(negedge clock);
            @(negedge clock);
            sif.pe_done = '0;
        end
        check("mid_diag", 32'(sif.diag), 32'd3);
        check("mid_busy", 32'(sif.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(sif.busy), 32'd0);
        check("abort_en", 32'(sif.pe_enable), 32'd0);
        check("abort_done", 32'(sif.job_done), 32'd0);
        check("abort_tag", 32'(sif.tag_out), 32'd0);
        reset = 1'b0;
        exp_tag = '0;
        @(negedge clock);
        check("post_abort_done", 32'(sif.job_done), 32'd0);
        do_start(4, 3);
        exp_tag++;
        check("restart_tag", 32'(sif.tag_out), 32'd1);
        run_body(4, 3, 20, 1'b1, nadv);
        check("restart_ndiag", 32'(nadv), 32'd6);

`ifdef SCHED_TIMEOUT_EN
        // PE1 never reports done on diagonal 1.
        do_start(2, 2);
        exp_tag++;
        sif.pe_done = sif.pe_enable;
        @(negedge clock);
        @(negedge clock);
        check("to_en", 32'(sif.pe_enable), 32'b0011);
        sif.pe_done = 4'b0001;
        repeat (15) begin
            @(negedge clock);
            check("to_early", 32'(sif.timeout_err), 32'd0);
            check("to_busy", 32'(sif.busy), 32'd1);
        end
        @(negedge clock);
        check("to_pulse", 32'(sif.timeout_err), 32'd1);
        check("to_idle", 32'(sif.busy), 32'd0);
        check("to_en_clr", 32'(sif.pe_enable), 32'd0);
        check("to_no_done", 32'(sif.job_done), 32'd0);
        @(negedge clock);
        check("to_clear", 32'(sif.timeout_err), 32'd0);
        drive_idle();
`endif

        // Randomized jobs with stalls, noisy done bits and ignored starts.
        for (int j = 0; j < 40; j++) begin
            r = int'($urandom_range(1, NUM_PE));
            h = int'($urandom_range(1, 8));
            do_start(r, h);
            exp_tag++;
            run_body(r, h, 30, 1'b1, nadv);
            check("rand_ndiag", 32'(nadv), 32'(r + h - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
